// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_unit_pkg;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer that parks a word acked while decode is frozen.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        full
);
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic        full_q, full_d;

  // clear wins over load so a redirect always empties the buffer
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    full_d  = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end
  end

  // buffer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      full_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      full_q  <= full_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign full  = full_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch + IF/ID register over a single-outstanding req/ack memory.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt IF/ID load counters.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PCOut,
  output logic        validOut
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d;
  logic [31:0] instr_q, instr_d, pcout_q, pcout_d;
  logic        req_q, req_d, valid_q, valid_d;
  logic [31:0] pc_next, skid_instr, skid_pc;
  logic        skid_load, skid_clear, skid_full;

  assign pc_next = pc_q + PC_STEP;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .instr_in (imem_rdata),
    .pc_in    (pc_next),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .full     (skid_full)
  );

  // next-state: redirect first, then per-state handshake; IF/ID bubbles when idle
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    pcout_d    = pcout_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (!freeze) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
    if (branch_taken) begin
      pc_d       = branch_addr & ~32'h3;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      // an in-flight request must still be retired before a new one goes out
      if ((state_q == S_WAIT || state_q == S_DISCARD) && !imem_ack) begin
        state_d = S_DISCARD;
      end else begin
        state_d = S_FETCH;
        req_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_ack) begin
            req_d = 1'b0;
            pc_d  = pc_next;
            if (!freeze) begin
              instr_d = imem_rdata;
              pcout_d = pc_next;
              valid_d = 1'b1;
              state_d = S_FETCH;
            end else begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            if (skid_full) begin
              instr_d = skid_instr;
              pcout_d = skid_pc;
              valid_d = 1'b1;
            end
            skid_clear = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // fetch state and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign PCOut       = pcout_q;
  assign validOut    = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic        ifid_upd;

  // IF/ID is rewritten whenever decode is not frozen or a redirect flushes it
  assign ifid_upd = branch_taken | ~freeze;

  // classify each IF/ID load as real instruction or bubble
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ifid_upd) begin
      if (valid_d) fetch_cnt_d  = fetch_cnt_q + 32'd1;
      else         bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, instruction, PCOut;
  logic        validOut;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .PCOut        (PCOut),
    .validOut     (validOut)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  // memory: ack after lat cycles of req held high (lat=0 acks in the req cycle)
  assign imem_ack   = imem_req && (wcnt == lat);
  assign imem_rdata = 32'h0400_0000 | imem_addr;
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pco,
                          input logic vld);
    chk({tag, ".instr"}, instruction, ins);
    chk({tag, ".pcout"}, PCOut, pco);
    chk({tag, ".valid"}, {31'b0, validOut}, {31'b0, vld});
  endtask

  task automatic chk_req(input string tag, input logic rq, input logic [31:0] ad);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, rq});
    if (rq) chk({tag, ".addr"}, imem_addr, ad);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    step(); step();
    chk_req("rst", 1'b0, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // zero-wait stream: 0,4,8 with bubbles in between
    step(); chk_req("f0", 1'b1, 32'h0);
    step(); chk_ifid("ld0", 32'h0400_0000, 32'h4, 1'b1); chk_req("ld0", 1'b0, 32'h0);
    step(); chk_ifid("bub0", 32'h0, 32'h4, 1'b0); chk_req("f4", 1'b1, 32'h4);
    step(); chk_ifid("ld4", 32'h0400_0004, 32'h8, 1'b1);
    step(); chk_ifid("bub4", 32'h0, 32'h8, 1'b0); chk_req("f8", 1'b1, 32'h8);

    // freeze at the ack of address 8
    freeze = 1'b1;
    step(); chk_req("frz1", 1'b0, 32'h0); chk_ifid("frz1", 32'h0, 32'h8, 1'b0);
    step(); chk_req("frz2", 1'b0, 32'h0); chk_ifid("frz2", 32'h0, 32'h8, 1'b0);
    freeze = 1'b0;
    step(); chk_ifid("unfrz", 32'h0400_0008, 32'hC, 1'b1); chk_req("unfrz", 1'b0, 32'h0);
    step(); chk_req("f12", 1'b1, 32'hC); chk_ifid("bub8", 32'h0, 32'hC, 1'b0);

    // three-cycle memory latency
    lat = 3;
    step(); chk_req("w1", 1'b1, 32'hC); chk("w1.valid", {31'b0, validOut}, 32'h0);
    step(); chk_req("w2", 1'b1, 32'hC); chk("w2.valid", {31'b0, validOut}, 32'h0);
    step(); chk_req("w3", 1'b1, 32'hC); chk("w3.ack", {31'b0, imem_ack}, 32'h1);
    step(); chk_ifid("ld12", 32'h0400_000C, 32'h10, 1'b1);
    step(); chk_req("f16", 1'b1, 32'h10);

    // branch while waiting on 16: flush, discard late ack, refetch at 0x40
    branch_taken = 1'b1; branch_addr = 32'h40;
    step(); branch_taken = 1'b0;
    chk_ifid("br", 32'h0, 32'h10, 1'b0); chk_req("disc1", 1'b1, 32'h10);
    step(); chk_req("disc2", 1'b1, 32'h10);
    step(); chk_req("disc3", 1'b1, 32'h10);
    step(); chk_req("drop", 1'b0, 32'h0); chk_ifid("drop", 32'h0, 32'h10, 1'b0);
    step(); chk_req("f40", 1'b1, 32'h40);

    // branch coincident with ack and freeze: branch wins, low addr bits masked
    lat = 0; branch_taken = 1'b1; branch_addr = 32'h83; freeze = 1'b1;
    step(); branch_taken = 1'b0; freeze = 1'b0;
    chk_req("brack", 1'b0, 32'h0); chk_ifid("brack", 32'h0, 32'h10, 1'b0);
    step(); chk_req("f80", 1'b1, 32'h80);
    step(); chk_ifid("ld80", 32'h0400_0080, 32'h84, 1'b1);

    // reset pulsed during WAIT
    lat = 3;
    step(); chk_req("f84", 1'b1, 32'h84);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk_req("rst2", 1'b0, 32'h0); chk("rst2.addr", imem_addr, 32'h0);
    chk_ifid("rst2", 32'h0, 32'h0, 1'b0);
    step(); chk_req("rf0", 1'b1, 32'h0);

    // PC wrap at top of address space
    lat = 0;
    step(); chk_ifid("rld0", 32'h0400_0000, 32'h4, 1'b1);
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step(); branch_taken = 1'b0; chk_req("brf", 1'b0, 32'h0);
    step(); chk_req("ftop", 1'b1, 32'hFFFF_FFFC);
    step(); chk_ifid("ldtop", 32'hFFFF_FFFC, 32'h0, 1'b1);
    step(); chk_req("wrap", 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
